// File: rtl/sl_pkg.sv
// Shared definitions for the SL line transmitter and receiver.
//   sl_tx_state_t  : transmitter frame state
//   MIN_WORD_LEN   : shortest data word carried in a frame
//   SL_WORD_LIMIT  : widest data word any SL block supports
//   sl_odd_parity  : parity bit that makes the count of 1s (data + parity) odd
package sl_pkg;

  localparam int unsigned MIN_WORD_LEN  = 8;
  localparam int unsigned SL_WORD_LIMIT = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    GAP    = 3'd4
  } sl_tx_state_t;

  // Only the low 'len' bits of 'data' take part in the parity.
  function automatic logic sl_odd_parity(input logic [SL_WORD_LIMIT-1:0] data,
                                         input int unsigned              len);
    logic acc;
    acc = 1'b0;
    for (int unsigned i = 0; i < SL_WORD_LIMIT; i++) begin
      if (i < len) acc = acc ^ data[i];
    end
    return ~acc;
  endfunction

endpackage

// File: rtl/sl_symbol_timer.sv
// Symbol timer for the SL transmitter: a start pulse begins a symbol of LOW_TICKS
// low-phase cycles followed by HIGH_TICKS high-phase cycles (HIGH_TICKS >= 1).
// The cycle after 'start' is the first low cycle. A start on the last cycle of a
// symbol chains the next symbol with no idle cycle.
// Optional feature macro: SL_TX_ERR_INJ_EN (adds mid_high_next).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           begin a symbol on the next cycle
//   sym_done        registered: this cycle is the last cycle of the symbol
//   phase_low_next  next cycle is in the low phase (feeds registered line outputs)
//   sym_done_next   next cycle is the last cycle of the symbol
//   mid_high_next   next cycle is the middle cycle of the high phase
module sl_symbol_timer #(
  parameter int unsigned LOW_TICKS  = 16,
  parameter int unsigned HIGH_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic sym_done,
  output logic phase_low_next,
  output logic sym_done_next
`ifdef SL_TX_ERR_INJ_EN
  ,
  output logic mid_high_next
`endif
);

  localparam int unsigned PERIOD = LOW_TICKS + HIGH_TICKS;
  localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          done_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (cnt_q == CW'(PERIOD - 1)) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign phase_low_next = active_d && (cnt_d < CW'(LOW_TICKS));
  assign sym_done_next  = active_d && (cnt_d == CW'(PERIOD - 1));
`ifdef SL_TX_ERR_INJ_EN
  assign mid_high_next  = active_d && (cnt_d == CW'(LOW_TICKS + HIGH_TICKS / 2));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= sym_done_next;
    end
  end

  assign sym_done = done_q;

endmodule

// File: rtl/sl_tx_frame_gen.sv
// SL line transmitter. Each accepted word is sent as one frame on two idle-high
// pulse lines: LSB-first data symbols (low pulse on sl1 = 1, on sl0 = 0), an odd
// parity symbol, a stop symbol (both lines low), then GAP_TICKS idle-high cycles.
// Word length per frame comes from tx_len, clamped to MIN_WORD_LEN..MAX_WORD_LEN.
// All outputs are driven straight from flops.
// Optional feature macro: SL_TX_ERR_INJ_EN (adds ei_parity / ei_glitch inputs).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   tx_valid     word available; accepted when tx_ready is high at a rising edge
//   tx_ready     block idle, can accept
//   tx_data      word, bit 0 sent first
//   tx_len       data bits this frame
//   sl0, sl1     pulse lines, idle high
//   busy         frame in progress
//   frame_done   one-cycle pulse on the last cycle of the frame
//   ei_parity    (optional) invert the parity bit of this frame
//   ei_glitch    (optional) 1-cycle low on the inactive line mid-HIGH of data bit 0
module sl_tx_frame_gen
  import sl_pkg::*;
#(
  parameter int unsigned MAX_WORD_LEN = 32,
  parameter int unsigned LOW_TICKS    = 16,
  parameter int unsigned HIGH_TICKS   = 16,
  parameter int unsigned GAP_TICKS    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  input  logic [MAX_WORD_LEN-1:0]           tx_data,
  input  logic [$clog2(MAX_WORD_LEN+1)-1:0] tx_len,
  output logic                              sl0,
  output logic                              sl1,
  output logic                              busy,
  output logic                              frame_done
`ifdef SL_TX_ERR_INJ_EN
  ,
  input  logic                              ei_parity,
  input  logic                              ei_glitch
`endif
);

  localparam int unsigned LW = $clog2(MAX_WORD_LEN + 1);
  localparam int unsigned IW = $clog2(MAX_WORD_LEN);
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  sl_tx_state_t            state_q, state_d;
  logic [IW-1:0]           bit_idx_q, bit_idx_d;
  logic [IW-1:0]           last_idx_q, last_idx_d;
  logic [MAX_WORD_LEN-1:0] data_q, data_d;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
  logic                    sl0_q, sl0_d, sl1_q, sl1_d;
  logic                    ready_q, busy_q, done_q, done_d;
  logic [LW-1:0]           len_clamped;
  logic [SL_WORD_LIMIT-1:0] data_ext;
  int unsigned             len_arg;
  logic                    accept, sym_start, cur_bit, par_bit;
  logic                    sym_done, low_next, done_next;
`ifdef SL_TX_ERR_INJ_EN
  logic                    ei_parity_q, ei_parity_d, ei_glitch_q, ei_glitch_d, mid_next;
`endif

  sl_symbol_timer #(
    .LOW_TICKS  (LOW_TICKS),
    .HIGH_TICKS (HIGH_TICKS)
  ) u_symbol_timer (
    .clk            (clk),
    .reset          (reset),
    .start          (sym_start),
    .sym_done       (sym_done),
    .phase_low_next (low_next),
    .sym_done_next  (done_next)
`ifdef SL_TX_ERR_INJ_EN
    ,
    .mid_high_next  (mid_next)
`endif
  );

  // Frame sequencing.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    data_d     = data_q;
    gap_cnt_d  = gap_cnt_q;
    sym_start  = 1'b0;
    accept     = 1'b0;

    len_clamped = tx_len;
    if (tx_len < LW'(MIN_WORD_LEN)) begin
      len_clamped = LW'(MIN_WORD_LEN);
    end else if (tx_len > LW'(MAX_WORD_LEN)) begin
      len_clamped = LW'(MAX_WORD_LEN);
    end

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          accept     = 1'b1;
          state_d    = DATA;
          data_d     = tx_data;
          last_idx_d = IW'(len_clamped - LW'(1));
          bit_idx_d  = '0;
          sym_start  = 1'b1;
        end
      end
      DATA: begin
        if (sym_done) begin
          sym_start = 1'b1;
          if (bit_idx_q == last_idx_q) begin
            state_d = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (sym_done) begin
          sym_start = 1'b1;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (sym_done) begin
          if (GAP_TICKS == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SL_TX_ERR_INJ_EN
  assign ei_parity_d = accept ? ei_parity : ei_parity_q;
  assign ei_glitch_d = accept ? ei_glitch : ei_glitch_q;
`endif

  // Line values for the next cycle, so sl0/sl1 come straight from flops.
  always_comb begin
    data_ext                   = '0;
    data_ext[MAX_WORD_LEN-1:0] = data_q;
    len_arg                    = 32'(last_idx_q) + 32'd1;
`ifdef SL_TX_ERR_INJ_EN
    par_bit = sl_odd_parity(data_ext, len_arg) ^ ei_parity_q;
`else
    par_bit = sl_odd_parity(data_ext, len_arg);
`endif
    cur_bit = data_d[bit_idx_d];
    sl0_d   = 1'b1;
    sl1_d   = 1'b1;

    unique case (state_d)
      DATA: begin
        sl0_d = ~(low_next & ~cur_bit);
        sl1_d = ~(low_next & cur_bit);
`ifdef SL_TX_ERR_INJ_EN
        if (ei_glitch_d && (bit_idx_d == '0) && mid_next) begin
          if (cur_bit) sl0_d = 1'b0;
          else         sl1_d = 1'b0;
        end
`endif
      end
      PARITY: begin
        sl0_d = ~(low_next & ~par_bit);
        sl1_d = ~(low_next & par_bit);
      end
      STOP: begin
        sl0_d = ~low_next;
        sl1_d = ~low_next;
      end
      default: ;
    endcase

    // With no gap the frame ends on the last stop cycle.
    if (GAP_TICKS == 0) begin
      done_d = (state_d == STOP) && done_next;
    end else begin
      done_d = (state_d == GAP) && (gap_cnt_d == GW'(GAP_TICKS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      last_idx_q  <= '0;
      data_q      <= '0;
      gap_cnt_q   <= '0;
      sl0_q       <= 1'b1;
      sl1_q       <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SL_TX_ERR_INJ_EN
      ei_parity_q <= 1'b0;
      ei_glitch_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      last_idx_q  <= last_idx_d;
      data_q      <= data_d;
      gap_cnt_q   <= gap_cnt_d;
      sl0_q       <= sl0_d;
      sl1_q       <= sl1_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
`ifdef SL_TX_ERR_INJ_EN
      ei_parity_q <= ei_parity_d;
      ei_glitch_q <= ei_glitch_d;
`endif
    end
  end

  assign sl0        = sl0_q;
  assign sl1        = sl1_q;
  assign tx_ready   = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sl_tx_frame_gen.sv
// Testbench for sl_tx_frame_gen: a default-parameter instance and a short-timing
// instance (LOW=4, HIGH=2, GAP=0), checked cycle by cycle against a waveform
// model built from the frame rules. Error-injection scenarios run when
// SL_TX_ERR_INJ_EN is defined.
module tb_sl_tx_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v1, rdy1, s0_1, s1_1, busy1, done1;
  logic [31:0] d1;
  logic [5:0]  len1;
  logic        v2, rdy2, s0_2, s1_2, busy2, done2;
  logic [31:0] d2;
  logic [5:0]  len2;
  logic        ep1, eg1;

  sl_tx_frame_gen dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (v1),
    .tx_ready   (rdy1),
    .tx_data    (d1),
    .tx_len     (len1),
    .sl0        (s0_1),
    .sl1        (s1_1),
    .busy       (busy1),
    .frame_done (done1)
`ifdef SL_TX_ERR_INJ_EN
    ,
    .ei_parity  (ep1),
    .ei_glitch  (eg1)
`endif
  );

  sl_tx_frame_gen #(
    .MAX_WORD_LEN (32),
    .LOW_TICKS    (4),
    .HIGH_TICKS   (2),
    .GAP_TICKS    (0)
  ) dut_short (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (v2),
    .tx_ready   (rdy2),
    .tx_data    (d2),
    .tx_len     (len2),
    .sl0        (s0_2),
    .sl1        (s1_2),
    .busy       (busy2),
    .frame_done (done2)
`ifdef SL_TX_ERR_INJ_EN
    ,
    .ei_parity  (1'b0),
    .ei_glitch  (1'b0)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  logic obs0 [4096];
  logic obs1 [4096];
  logic exp0 [4096];
  logic exp1 [4096];
  int   exp_n, obs_ready, obs_done_cnt, obs_done_cyc, obs_busy_low;

  // Expected line trace of one frame, index 0 = first cycle after accept.
  task automatic build_exp(input logic [31:0] data, input int len_raw, input int lt,
                           input int ht, input int gt, input bit ei_par, input bit ei_gl);
    int n, k, ones;
    bit b, p;
    n    = (len_raw < 8) ? 8 : ((len_raw > 32) ? 32 : len_raw);
    k    = 0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      b = data[i];
      ones += int'(b);
      for (int c = 0; c < lt + ht; c++) begin
        exp0[k] = !(c < lt && !b);
        exp1[k] = !(c < lt && b);
        if (ei_gl && i == 0 && c == lt + ht / 2) begin
          if (b) exp0[k] = 1'b0;
          else   exp1[k] = 1'b0;
        end
        k++;
      end
    end
    p = ((ones % 2) == 0) ^ ei_par;
    for (int c = 0; c < lt + ht; c++) begin
      exp0[k] = !(c < lt && !p);
      exp1[k] = !(c < lt && p);
      k++;
    end
    for (int c = 0; c < lt + ht; c++) begin
      exp0[k] = !(c < lt);
      exp1[k] = !(c < lt);
      k++;
    end
    for (int c = 0; c < gt; c++) begin
      exp0[k] = 1'b1;
      exp1[k] = 1'b1;
      k++;
    end
    exp_n = k;
  endtask

  task automatic send(input int which, input logic [31:0] data, input logic [5:0] len,
                      input bit hold);
    int waited;
    waited = 0;
    while (!((which == 1) ? rdy1 : rdy2) && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 3000) begin
      checks++; failures++;
      $display("FAIL send_wait: tx_ready still 0 after %0d cycles, need 1", waited);
    end
    if (which == 1) begin v1 = 1'b1; d1 = data; len1 = len; end
    else            begin v2 = 1'b1; d2 = data; len2 = len; end
    @(posedge clk); #1;
    if (!hold) begin v1 = 1'b0; v2 = 1'b0; end
  endtask

  // Records lines from the first cycle after accept until tx_ready returns.
  task automatic capture(input int which);
    logic r;
    for (int i = 0; i < 4096; i++) begin obs0[i] = 1'bx; obs1[i] = 1'bx; end
    obs_ready = -1; obs_done_cnt = 0; obs_done_cyc = -1; obs_busy_low = 0;
    for (int k = 1; k <= 3000; k++) begin
      r = (which == 1) ? rdy1 : rdy2;
      if (r) begin obs_ready = k; break; end
      obs0[k-1] = (which == 1) ? s0_1 : s0_2;
      obs1[k-1] = (which == 1) ? s1_1 : s1_2;
      if ((which == 1) ? done1 : done2) begin obs_done_cnt++; obs_done_cyc = k; end
      if (!((which == 1) ? busy1 : busy2)) obs_busy_low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v1 = 0; d1 = '0; len1 = '0; v2 = 0; d2 = '0; len2 = '0; ep1 = 0; eg1 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s0_1 !== 1'b1) begin failures++; $display("FAIL reset_sl0: got %b need 1", s0_1); end
    checks++; if (s1_1 !== 1'b1) begin failures++; $display("FAIL reset_sl1: got %b need 1", s1_1); end
    checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b need 1", rdy1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b need 0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b need 0", done1); end
    checks++; if (rdy2 !== 1'b1 || s0_2 !== 1'b1 || s1_2 !== 1'b1) begin
      failures++; $display("FAIL reset_short: got rdy/sl0/sl1=%b%b%b need 111", rdy2, s0_2, s1_2);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_a5c3();
    int mism, first, stop_low;
    send(1, 32'h0000_A5C3, 6'd16, 1'b0);
    capture(1);
    build_exp(32'h0000_A5C3, 16, 16, 16, 16, 1'b0, 1'b0);
    mism = 0; first = -1;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
      if (first < 0) first = i;
      mism++;
    end
    checks++; if (mism != 0) begin failures++;
      $display("FAIL a5c3_wave: %0d bad cycles, first idx %0d got %b%b need %b%b",
               mism, first, obs0[first], obs1[first], exp0[first], exp1[first]);
    end
    checks++; if (obs_ready != 593) begin failures++;
      $display("FAIL a5c3_len: tx_ready after %0d cycles, need 593", obs_ready); end
    checks++; if (obs_done_cnt != 1 || obs_done_cyc != 592) begin failures++;
      $display("FAIL a5c3_done: %0d pulses at %0d, need 1 at 592", obs_done_cnt, obs_done_cyc); end
    checks++; if (obs_busy_low != 0) begin failures++;
      $display("FAIL a5c3_busy: busy low %0d cycles in frame, need 0", obs_busy_low); end
    checks++; if (obs1[512] !== 1'b0 || obs0[512] !== 1'b1) begin failures++;
      $display("FAIL a5c3_parity: sl0/sl1=%b%b need 10", obs0[512], obs1[512]); end
    stop_low = 0;
    for (int i = 544; i < 560; i++) if (obs0[i] === 1'b0 && obs1[i] === 1'b0) stop_low++;
    checks++; if (stop_low != 16) begin failures++;
      $display("FAIL a5c3_stop: both-low cycles %0d, need 16", stop_low); end
  endtask

  task automatic test_clamp();
    int lens [2] = '{4, 40};
    int wants [2] = '{337, 1105};
    int mism;
    logic [31:0] w;
    for (int t = 0; t < 2; t++) begin
      w = $urandom();
      send(1, w, 6'(lens[t]), 1'b0);
      capture(1);
      build_exp(w, lens[t], 16, 16, 16, 1'b0, 1'b0);
      mism = 0;
      for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
      checks++; if (mism != 0) begin failures++;
        $display("FAIL clamp_wave len=%0d: %0d bad cycles, need 0", lens[t], mism); end
      checks++; if (obs_ready != wants[t]) begin failures++;
        $display("FAIL clamp_len len=%0d: got %0d need %0d", lens[t], obs_ready, wants[t]); end
    end
  endtask

  task automatic test_back_to_back();
    int mism;
    send(1, 32'h0000_0001, 6'd32, 1'b1);
    capture(1);
    build_exp(32'h0000_0001, 32, 16, 16, 16, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
    checks++; if (mism != 0) begin failures++;
      $display("FAIL b2b_wave1: %0d bad cycles, need 0", mism); end
    checks++; if (obs0[1024] !== 1'b0 || obs1[1024] !== 1'b1) begin failures++;
      $display("FAIL b2b_parity1: sl0/sl1=%b%b need 01", obs0[1024], obs1[1024]); end
    checks++; if (obs_ready != 1105) begin failures++;
      $display("FAIL b2b_len1: got %0d need 1105", obs_ready); end
    d1 = 32'hFFFF_FFFF;  // tx_valid still high: accepted on this first idle cycle
    @(posedge clk); #1;
    v1 = 1'b0;
    capture(1);
    build_exp(32'hFFFF_FFFF, 32, 16, 16, 16, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
    checks++; if (mism != 0) begin failures++;
      $display("FAIL b2b_wave2: %0d bad cycles, need 0 (first sl0/sl1=%b%b)", mism, obs0[0], obs1[0]); end
    checks++; if (obs0[1024] !== 1'b1 || obs1[1024] !== 1'b0) begin failures++;
      $display("FAIL b2b_parity2: sl0/sl1=%b%b need 10", obs0[1024], obs1[1024]); end
  endtask

  task automatic test_reset_mid();
    int dn, mism;
    logic [31:0] w;
    w = $urandom();
    send(1, w, 6'd16, 1'b0);
    dn = 0;
    repeat (99) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (s0_1 !== 1'b1 || s1_1 !== 1'b1) begin failures++;
      $display("FAIL rstmid_lines: sl0/sl1=%b%b need 11", s0_1, s1_1); end
    checks++; if (rdy1 !== 1'b1 || busy1 !== 1'b0) begin failures++;
      $display("FAIL rstmid_ready: ready/busy=%b%b need 10", rdy1, busy1); end
    reset = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (done1 !== 1'b0) dn++;
      @(posedge clk); #1;
    end
    checks++; if (dn != 0) begin failures++;
      $display("FAIL rstmid_done: frame_done high %0d cycles, need 0", dn); end
    w = $urandom();
    send(1, w, 6'd12, 1'b0);
    capture(1);
    build_exp(w, 12, 16, 16, 16, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
    checks++; if (mism != 0 || obs_ready != exp_n + 1) begin failures++;
      $display("FAIL rstmid_next: %0d bad cycles, ready at %0d need 0 and %0d", mism,
               obs_ready, exp_n + 1);
    end
  endtask

  task automatic test_short_timing();
    int mism;
    logic [31:0] w;
    w = $urandom();
    send(2, w, 6'd8, 1'b0);
    capture(2);
    build_exp(w, 8, 4, 2, 0, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
    checks++; if (mism != 0) begin failures++;
      $display("FAIL short_wave: %0d bad cycles, need 0", mism); end
    checks++; if (obs_ready != 61) begin failures++;
      $display("FAIL short_len: got %0d need 61", obs_ready); end
    checks++; if (obs_done_cnt != 1 || obs_done_cyc != 60) begin failures++;
      $display("FAIL short_done: %0d pulses at %0d, need 1 at 60", obs_done_cnt, obs_done_cyc); end
  endtask

  task automatic test_random();
    int mism, len, which;
    logic [31:0] w;
    for (int t = 0; t < 12; t++) begin
      which = (t % 2) + 1;
      w     = $urandom();
      len   = $urandom_range(0, 63);
      send(which, w, 6'(len), 1'b0);
      capture(which);
      if (which == 1) build_exp(w, len, 16, 16, 16, 1'b0, 1'b0);
      else            build_exp(w, len, 4, 2, 0, 1'b0, 1'b0);
      mism = 0;
      for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
      checks++; if (mism != 0) begin failures++;
        $display("FAIL rand_wave dut%0d data=%h len=%0d: %0d bad cycles", which, w, len, mism); end
      checks++; if (obs_ready != exp_n + 1 || obs_done_cnt != 1 || obs_done_cyc != exp_n) begin
        failures++;
        $display("FAIL rand_timing dut%0d len=%0d: ready %0d done %0dx@%0d, need %0d 1x@%0d",
                 which, len, obs_ready, obs_done_cnt, obs_done_cyc, exp_n + 1, exp_n);
      end
    end
  endtask

`ifdef SL_TX_ERR_INJ_EN
  task automatic test_err_inj();
    int mism, lows;
    ep1 = 1'b1;
    send(1, 32'h0000_0001, 6'd8, 1'b0);
    ep1 = 1'b0;
    capture(1);
    build_exp(32'h0000_0001, 8, 16, 16, 16, 1'b1, 1'b0);
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
    checks++; if (mism != 0) begin failures++;
      $display("FAIL ei_parity_wave: %0d bad cycles, need 0", mism); end
    checks++; if (obs1[256] !== 1'b0 || obs0[256] !== 1'b1) begin failures++;
      $display("FAIL ei_parity_line: sl0/sl1=%b%b need 10", obs0[256], obs1[256]); end
    eg1 = 1'b1;
    send(1, 32'h0000_0002, 6'd8, 1'b0);
    eg1 = 1'b0;
    capture(1);
    build_exp(32'h0000_0002, 8, 16, 16, 16, 1'b0, 1'b1);
    mism = 0;
    for (int i = 0; i < exp_n; i++) if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) mism++;
    checks++; if (mism != 0) begin failures++;
      $display("FAIL ei_glitch_wave: %0d bad cycles, need 0", mism); end
    lows = 0;
    for (int i = 16; i < 32; i++) if (obs1[i] === 1'b0) lows++;
    checks++; if (lows != 1) begin failures++;
      $display("FAIL ei_glitch_count: sl1 low %0d cycles in bit0 HIGH phase, need 1", lows); end
  endtask
`endif

  initial begin
    test_reset();
    test_a5c3();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_short_timing();
    test_random();
`ifdef SL_TX_ERR_INJ_EN
    test_err_inj();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
